// File: rtl/core_fetch_if.sv
// -----------------------------------------------------------------------------
// d_if: fetch -> decode handshake.
//   pc    : byte address of the presented instruction
//   ir    : instruction word
//   valid : pc/ir hold a live instruction
//   ready : decode accepts the instruction this cycle (pops on valid & ready)
// The fetch stage connects through the 'slave' modport (it drives pc/ir/valid
// and consumes ready); decode uses 'master'.
// -----------------------------------------------------------------------------
interface d_if;
  logic [31:0] pc;
  logic [31:0] ir;
  logic        valid;
  logic        ready;

  modport slave  (output pc, output ir, output valid, input ready);
  modport master (input pc, input ir, input valid, output ready);
endinterface

// File: rtl/core_fetch.sv
// -----------------------------------------------------------------------------
// core_fetch: instruction-fetch stage of the in-order core.
//
// Owns the program counter, issues word-aligned requests on the imem port and
// buffers returned words in a small in-order queue presented to decode on d.
// A redirect from execute reloads the PC, flushes the queue and marks every
// in-flight response for discard.
//
// Parameters
//   RESET_PC        : first PC fetched after reset
//   QUEUE_DEPTH     : instruction queue entries (power of two, >= 2)
//   MAX_OUTSTANDING : granted-but-unanswered request limit (>= 1)
//
// Ports
//   clk, rst_n                : clock (rising edge), asynchronous active-low reset
//   imem_req/addr/gnt         : request channel (addr[1:0] always 0)
//   imem_rvalid/rdata         : in-order response channel, no back-pressure
//   redirect_valid/pc         : PC redirect from execute (highest priority)
//   d                         : decode interface (pc, ir, valid out; ready in)
//   fetch_misaligned          : only when CORE_FETCH_MISALIGN_EN is defined;
//                               set by a redirect to a non-word-aligned target,
//                               blocks fetch until an aligned redirect.
//
// Build option: define CORE_FETCH_MISALIGN_EN to enable misaligned-redirect
// detection. Without it redirect_pc[1:0] is ignored.
// -----------------------------------------------------------------------------
module core_fetch #(
  parameter logic [31:0] RESET_PC        = 32'h0000_0000,
  parameter int          QUEUE_DEPTH     = 2,
  parameter int          MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  d_if.slave          d
`ifdef CORE_FETCH_MISALIGN_EN
  ,
  output logic        fetch_misaligned
`endif
);

  localparam int QW = $clog2(QUEUE_DEPTH);
  localparam int CW = $clog2(QUEUE_DEPTH + 1);
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

  // PC is kept as a word address; the +1 increment then wraps
  // 0xFFFF_FFFC -> 0 for free.
  logic [29:0]   pc_word;
  logic [OW-1:0] outstanding;
  logic [OW-1:0] discard;
  logic [QW-1:0] head;
  logic [QW-1:0] tail;
  logic [CW-1:0] count;
  logic          misaligned;

  // Instruction queue storage (no reset needed, guarded by count).
  logic [29:0] q_pc [QUEUE_DEPTH];
  logic [31:0] q_ir [QUEUE_DEPTH];

  // PC of each granted request, consumed in order as responses return.
  logic [29:0]   rq_pc [MAX_OUTSTANDING];
  logic [PW-1:0] rq_wr;
  logic [PW-1:0] rq_rd;

  logic grant;
  logic resp_live;
  logic pop;
  int   credit;

  function automatic logic [PW-1:0] rq_inc(input logic [PW-1:0] p);
    return (int'(p) == MAX_OUTSTANDING - 1) ? '0 : p + PW'(1);
  endfunction

  // Every request counted here is guaranteed a queue slot when it returns,
  // which is why the response channel needs no back-pressure.
  assign credit    = int'(count) + int'(outstanding) - int'(discard);
  assign imem_req  = rst_n & ~redirect_valid & ~misaligned
                   & (int'(outstanding) < MAX_OUTSTANDING)
                   & (credit < QUEUE_DEPTH);
  assign imem_addr = {pc_word, 2'b00};
  assign grant     = imem_req & imem_gnt;
  // A response in the redirect cycle belongs to the old stream: drop it too.
  assign resp_live = imem_rvalid & (discard == '0) & ~redirect_valid;
  assign pop       = (count != '0) & d.ready;

  assign d.valid = (count != '0);
  assign d.pc    = (count != '0) ? {q_pc[head], 2'b00} : 32'h0;
  assign d.ir    = (count != '0) ? q_ir[head] : 32'h0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_word     <= RESET_PC[31:2];
      outstanding <= '0;
      discard     <= '0;
      head        <= '0;
      tail        <= '0;
      count       <= '0;
      rq_wr       <= '0;
      rq_rd       <= '0;
    end else begin
      // Grant and response in one cycle cancel out.
      if (grant & ~imem_rvalid)
        outstanding <= outstanding + OW'(1);
      else if (~grant & imem_rvalid)
        outstanding <= outstanding - OW'(1);

      if (grant)       rq_wr <= rq_inc(rq_wr);
      if (imem_rvalid) rq_rd <= rq_inc(rq_rd);

      if (redirect_valid) begin
        pc_word <= redirect_pc[31:2];
        // Everything still in flight after this cycle's response is stale.
        discard <= outstanding - OW'(imem_rvalid);
        count   <= '0;
        head    <= tail;
      end else begin
        if (grant)
          pc_word <= pc_word + 30'd1;
        if (imem_rvalid && discard != '0)
          discard <= discard - OW'(1);
        if (resp_live)
          tail <= tail + QW'(1);
        if (pop)
          head <= head + QW'(1);
        if (resp_live & ~pop)
          count <= count + CW'(1);
        else if (~resp_live & pop)
          count <= count - CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (grant)
      rq_pc[rq_wr] <= pc_word;
    if (resp_live) begin
      q_pc[tail] <= rq_pc[rq_rd];
      q_ir[tail] <= imem_rdata;
    end
  end

`ifdef CORE_FETCH_MISALIGN_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      misaligned <= 1'b0;
    else if (redirect_valid)
      misaligned <= |redirect_pc[1:0];
  end

  assign fetch_misaligned = misaligned;
`else
  logic unused_redirect_low;
  assign misaligned          = 1'b0;
  assign unused_redirect_low = ^redirect_pc[1:0];
`endif

endmodule
